seg7_priority_capture: RTL and testbench

- Receive end of the priority-encoder display interface: samples a 7-segment bus (gfedcba) plus the "none" (dp) line from a display driver.
- Qualifies the pattern as stable, then decodes it back to the 3-bit priority index and a one-hot data vector.
- Presents each newly stable pattern once on a valid/ready output port.
- Used for loopback checking of the encoder output on the board and as a capture front-end for downstream logic.

---
 rtl/seg7_priority_capture.sv | 132 +++++++++++++
 tb/tb_seg7_priority_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_priority_capture.sv
// Receive side of the 7-segment priority display link. It synchronises the
// segment bus, waits until the pattern is stable, then decodes it and reports it once.
module seg7_priority_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       none_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_index,
  output logic [7:0] out_onehot,
  output logic       out_none,
  output logic       out_error,
  output logic [7:0] out_pattern
);

  typedef enum logic {WAIT, PRESENT} state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  state_t     state, state_nx;
  logic [7:0] s1, s2, s_prev, cnt, last_rep;
  logic       rep_valid;
  logic       stable, capture;

  logic [2:0] code_idx;
  logic       code_hit;
  logic [2:0] dec_index;
  logic [7:0] dec_onehot;
  logic       dec_none, dec_error;

  // Two-flop synchroniser plus the stability counter on the synchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      s_prev <= '0;
      cnt    <= '0;
    end else begin
      s1     <= {none_in, seg_in};
      s2     <= s1;
      s_prev <= s2;
      if (s2 != s_prev)
        cnt <= '0;
      else if (cnt < STABLE_W)
        cnt <= cnt + 8'd1;
    end
  end

  assign stable = (s2 == s_prev) && (cnt >= STABLE_W - 8'd1);

  always_comb begin
    code_idx = '0;
    code_hit = 1'b0;
    case (s2[6:0])
      7'b0111111: begin code_idx = 3'd0; code_hit = 1'b1; end
      7'b0000110: begin code_idx = 3'd1; code_hit = 1'b1; end
      7'b1011011: begin code_idx = 3'd2; code_hit = 1'b1; end
      7'b1001111: begin code_idx = 3'd3; code_hit = 1'b1; end
      7'b1100110: begin code_idx = 3'd4; code_hit = 1'b1; end
      7'b1101101: begin code_idx = 3'd5; code_hit = 1'b1; end
      7'b1111101: begin code_idx = 3'd6; code_hit = 1'b1; end
      7'b0000111: begin code_idx = 3'd7; code_hit = 1'b1; end
      default:    begin code_idx = '0;   code_hit = 1'b0; end
    endcase
  end

  always_comb begin
    dec_index  = '0;
    dec_onehot = '0;
    dec_none   = 1'b0;
    dec_error  = 1'b0;
    if (s2[7]) begin
      if (s2[6:0] == 7'd0) dec_none  = 1'b1;
      else                 dec_error = 1'b1;
    end else if (code_hit) begin
      dec_index  = code_idx;
      dec_onehot = 8'd1 << code_idx;
    end else begin
      dec_error = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      WAIT: begin
        if (stable && (!rep_valid || s2 != last_rep)) begin
          capture  = 1'b1;
          state_nx = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) state_nx = WAIT;
      end
      default: state_nx = WAIT;
    endcase
  end

  // Result registers only move on capture; acceptance clears just out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT;
      last_rep    <= '0;
      rep_valid   <= 1'b0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      out_onehot  <= '0;
      out_none    <= 1'b0;
      out_error   <= 1'b0;
      out_pattern <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        out_valid   <= 1'b1;
        out_index   <= dec_index;
        out_onehot  <= dec_onehot;
        out_none    <= dec_none;
        out_error   <= dec_error;
        out_pattern <= s2;
        last_rep    <= s2;
        rep_valid   <= 1'b1;
      end else if (state == PRESENT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_priority_capture.sv
// Self-checking bench for seg7_priority_capture: directed corner sequences,
// a decode vector table and randomized traffic against a reference model.
module tb_seg7_priority_capture;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = '0;
  logic       none_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_index;
  logic [7:0] out_onehot;
  logic       out_none;
  logic       out_error;
  logic [7:0] out_pattern;

  seg7_priority_capture #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .none_in(none_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_index(out_index),
    .out_onehot(out_onehot), .out_none(out_none), .out_error(out_error),
    .out_pattern(out_pattern)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] codes [8];

  // Reference model: delayed view of the input and how long it has been held.
  logic [7:0] m_s1, m_s2, m_last, m_pat;
  int         m_run;
  bit         m_have, m_ov;
  logic [2:0] m_idx;
  logic [7:0] m_oh;
  logic       m_nn, m_er;

  typedef struct {
    logic       none;
    logic [6:0] seg;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       nn;
    logic       er;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] ref_decode(input logic [7:0] p);
    if (p[7]) return (p[6:0] == 7'd0) ? 13'b0_1_00000000_000 : 13'b1_0_00000000_000;
    for (int i = 0; i < 8; i++)
      if (codes[i] == p[6:0]) return {2'b00, 8'(1 << i), 3'(i)};
    return 13'b1_0_00000000_000;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_run = 2; m_have = 0; m_ov = 0; m_last = '0;
    m_idx = '0; m_oh = '0; m_nn = 0; m_er = 0; m_pat = '0;
  endtask

  task automatic model_edge();
    logic [7:0] nxt;
    if (!m_ov) begin
      if (m_run >= SC + 1 && (!m_have || m_s2 != m_last)) begin
        {m_er, m_nn, m_oh, m_idx} = ref_decode(m_s2);
        m_pat = m_s2; m_last = m_s2; m_have = 1; m_ov = 1;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    nxt   = m_s1;
    m_run = (nxt == m_s2) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_s2  = nxt;
    m_s1  = {none_in, seg_in};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model", {out_valid, out_index, out_onehot, out_none, out_error, out_pattern},
        {m_ov, m_idx, m_oh, m_nn, m_er, m_pat});
  endtask

  task automatic wait_valid(input int max, output int edges);
    edges = 0;
    while (edges < max) begin
      step();
      edges++;
      if (out_valid) return;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drive(input logic n, input logic [6:0] s);
    none_in = n;
    seg_in  = s;
  endtask

  initial begin
    int e;
    int cnt;
    codes[0] = 7'b0111111; codes[1] = 7'b0000110; codes[2] = 7'b1011011;
    codes[3] = 7'b1001111; codes[4] = 7'b1100110; codes[5] = 7'b1101101;
    codes[6] = 7'b1111101; codes[7] = 7'b0000111;

    tbl[0]  = '{1'b0, 7'b0111111, 3'd0, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 7'b0000110, 3'd1, 8'h02, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 7'b1011011, 3'd2, 8'h04, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 7'b1001111, 3'd3, 8'h08, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 7'b1100110, 3'd4, 8'h10, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 7'b1101101, 3'd5, 8'h20, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 7'b1111101, 3'd6, 8'h40, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 7'b0000111, 3'd7, 8'h80, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 7'b0000000, 3'd0, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 7'b0111111, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 7'b1111111, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 7'b0000000, 3'd0, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 7'b1101101, 3'd0, 8'h00, 1'b0, 1'b1};

    model_reset();
    drive(1'b1, 7'b0000000);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {out_valid, out_index, out_onehot, out_none, out_error, out_pattern}, 0);
    rst = 1'b0;

    // Blank after reset: reported 7 edges after the first sampling edge, exactly once.
    wait_valid(20, e);
    chk("blank_latency", e, 7);
    chk("blank_none", {out_none, out_onehot}, 9'h100);
    step();
    chk("blank_drop", out_valid, 0);
    cnt = 0;
    repeat (10) begin step(); cnt += int'(out_valid); end
    chk("blank_no_repeat", cnt, 0);

    // Digit 6 held while the consumer stalls for 20 cycles.
    out_ready = 1'b0;
    drive(1'b0, 7'b1111101);
    wait_valid(20, e);
    cnt = 0;
    repeat (20) begin
      step();
      if (!(out_valid && out_index == 3'd6 && out_onehot == 8'h40)) cnt++;
    end
    chk("stall_hold", cnt, 0);
    out_ready = 1'b1;
    step();
    chk("stall_release", out_valid, 0);

    // Toggling faster than the window is never reported.
    cnt = 0;
    repeat (8) begin
      drive(1'b0, 7'b0000110);
      repeat (3) begin step(); cnt += int'(out_valid); end
      drive(1'b0, 7'b1011011);
      repeat (3) begin step(); cnt += int'(out_valid); end
    end
    chk("toggle_silent", cnt, 0);
    wait_valid(20, e);
    chk("toggle_settle", {out_index, out_onehot}, {3'd2, 8'h04});
    step();

    // Glitch and return to the same pattern does not re-report.
    drive(1'b0, 7'b0000111);
    wait_valid(20, e);
    chk("glitch_first", out_index, 7);
    step();
    drive(1'b0, 7'b0000000);
    step();
    drive(1'b0, 7'b0000111);
    cnt = 0;
    repeat (15) begin step(); cnt += int'(out_valid); end
    chk("glitch_no_repeat", cnt, 0);
    drive(1'b0, 7'b1001111);
    wait_valid(20, e);
    chk("glitch_next", {out_index, out_onehot}, {3'd3, 8'h08});
    step();

    // Decode table, each entry presented and accepted.
    for (int i = 0; i < 13; i++) begin
      out_ready = 1'b0;
      drive(tbl[i].none, tbl[i].seg);
      wait_valid(20, e);
      chk($sformatf("tbl%0d", i),
          {out_index, out_onehot, out_none, out_error, out_pattern},
          {tbl[i].idx, tbl[i].oh, tbl[i].nn, tbl[i].er, tbl[i].none, tbl[i].seg});
      out_ready = 1'b1;
      step();
    end

    // Asynchronous reset while a result is pending.
    out_ready = 1'b0;
    drive(1'b0, 7'b1101101);
    wait_valid(20, e);
    chk("pre_reset_idx", out_index, 5);
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {out_valid, out_index, out_onehot, out_none, out_error, out_pattern}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_valid(20, e);
    chk("post_reset_latency", e, 7);
    chk("post_reset_idx", {out_index, out_onehot}, {3'd5, 8'h20});

    // Randomized traffic against the model.
    repeat (300) begin
      int sel;
      int hold;
      sel = int'($urandom_range(0, 11));
      if (sel < 8)       drive(1'b0, codes[sel]);
      else if (sel == 8) drive(1'b1, 7'b0000000);
      else               drive(1'($urandom), 7'($urandom));
      hold = int'($urandom_range(1, 10));
      repeat (hold) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
